// File: rtl/arm_reg_file_mp.sv
// Multi-port ARM register file: NUM_RD read ports, ALU and writeback write ports,
// PC update path with auto-increment, link capture, masked flags, load-pending scoreboard.
// Reads are combinational (optionally forwarding this cycle's writes); no back-pressure.
module arm_reg_file_mp #(
   parameter int DATA_W   = 32,
   parameter int NUM_REGS = 16,
   parameter int NUM_RD   = 3,
   parameter int FLAG_W   = 4,
   parameter int PC_INC   = 4,
   parameter int BYPASS   = 1,
   localparam int AW      = $clog2(NUM_REGS)
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [NUM_RD*AW-1:0]     rd_sel,
   output logic [NUM_RD*DATA_W-1:0] rd_data,
   output logic [NUM_RD-1:0]        rd_pending,
   input  logic                     wa_en,
   input  logic [AW-1:0]            wa_sel,
   input  logic [DATA_W-1:0]        wa_data,
   input  logic                     wb_en,
   input  logic [AW-1:0]            wb_sel,
   input  logic [DATA_W-1:0]        wb_data,
   input  logic                     pc_wr_en,
   input  logic [DATA_W-1:0]        pc_wr_data,
   input  logic                     pc_inc_en,
   input  logic                     link_en,
   input  logic [FLAG_W-1:0]        flag_mask,
   input  logic [FLAG_W-1:0]        flag_data,
   output logic [FLAG_W-1:0]        flags,
   output logic [DATA_W-1:0]        pc_out,
   input  logic                     lock_en,
   input  logic [AW-1:0]            lock_sel
);

   localparam int PC_IDX = NUM_REGS - 1;
   localparam int LR_IDX = NUM_REGS - 2;
   localparam logic [AW-1:0] PC_SEL = AW'(PC_IDX);

   logic [DATA_W-1:0] regs    [NUM_REGS];
   logic [DATA_W-1:0] reg_nxt [NUM_REGS];
   logic [NUM_REGS-1:0] pending;
   logic [NUM_REGS-1:0] pend_nxt;
   logic [FLAG_W-1:0]   flags_q;
   logic wa_pc;
   logic wb_pc;
   logic link_cap;

   assign wa_pc    = wa_en && (wa_sel == PC_SEL);
   assign wb_pc    = wb_en && (wb_sel == PC_SEL);
   // Link only follows an explicit redirect (ALU write to PC or branch target), not a load into PC.
   assign link_cap = link_en && (wa_pc || pc_wr_en);

   // Next value of every register after this edge: link > wa > wb > PC write/increment > hold.
   always_comb begin
      for (int r = 0; r < NUM_REGS; r++) begin
         reg_nxt[r] = regs[r];
         if (wb_en && (wb_sel == AW'(r))) reg_nxt[r] = wb_data;
         if (wa_en && (wa_sel == AW'(r))) reg_nxt[r] = wa_data;
      end
      if (!wa_pc && !wb_pc) begin
         if (pc_wr_en)       reg_nxt[PC_IDX] = pc_wr_data;
         else if (pc_inc_en) reg_nxt[PC_IDX] = regs[PC_IDX] + DATA_W'(PC_INC);
      end
      if (link_cap) reg_nxt[LR_IDX] = regs[PC_IDX];
   end

   // Scoreboard next state: writeback clears, lock sets, lock wins on the same register.
   always_comb begin
      pend_nxt = pending;
      if (wb_en)   pend_nxt[wb_sel]   = 1'b0;
      if (lock_en) pend_nxt[lock_sel] = 1'b1;
   end

   // State registers; synchronous reset clears everything.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int r = 0; r < NUM_REGS; r++) regs[r] <= '0;
         pending <= '0;
         flags_q <= '0;
      end else begin
         for (int r = 0; r < NUM_REGS; r++) regs[r] <= reg_nxt[r];
         pending <= pend_nxt;
         flags_q <= (flags_q & ~flag_mask) | (flag_data & flag_mask);
      end
   end

   // Read ports: stored state, or the post-edge value when forwarding is enabled.
   always_comb begin
      rd_data    = '0;
      rd_pending = '0;
      for (int i = 0; i < NUM_RD; i++) begin
         if (BYPASS != 0) begin
            rd_data[i*DATA_W +: DATA_W] = reset ? '0 : reg_nxt[rd_sel[i*AW +: AW]];
            rd_pending[i] = pending[rd_sel[i*AW +: AW]] &
                            ~(wb_en && (wb_sel == rd_sel[i*AW +: AW]));
         end else begin
            rd_data[i*DATA_W +: DATA_W] = regs[rd_sel[i*AW +: AW]];
            rd_pending[i] = pending[rd_sel[i*AW +: AW]];
         end
      end
   end

   assign flags  = flags_q;
   assign pc_out = regs[PC_IDX];

endmodule
